// File: rtl/item_pkg.sv
// Shared item-layer definitions: type codes, ROM selectors, colours, sprite contents.
package item_pkg;

    localparam int SPRITE_DEF = 24;
    localparam int CELL_DEF   = 20;
    localparam int ORIGIN_DEF = 80;
    localparam int SPRITE_PIX = SPRITE_DEF * SPRITE_DEF;

    // Item type codes as loaded through set_type
    typedef enum logic [2:0] {
        ITEM_NONE    = 3'd0,
        ITEM_PROTECT = 3'd1,
        ITEM_FASTER  = 3'd2,
        ITEM_FROZEN  = 3'd3,
        ITEM_LASER   = 3'd4
    } item_type_e;

    // Sprite ROM selector; type 1 maps to protect or addtime depending on game mode
    typedef enum logic [2:0] {
        SEL_ADDTIME = 3'd0,
        SEL_PROTECT = 3'd1,
        SEL_FASTER  = 3'd2,
        SEL_FROZEN  = 3'd3,
        SEL_LASER   = 3'd4
    } sprite_sel_e;

    localparam logic [11:0] COL_PROTECT = 12'h0FF;
    localparam logic [11:0] COL_FASTER  = 12'hFF0;
    localparam logic [11:0] COL_FROZEN  = 12'h00F;
    localparam logic [11:0] COL_LASER   = 12'hF00;

    function automatic logic [11:0] type_colour(input logic [2:0] t);
        logic [11:0] c;
        case (t)
            ITEM_PROTECT: c = COL_PROTECT;
            ITEM_FASTER:  c = COL_FASTER;
            ITEM_FROZEN:  c = COL_FROZEN;
            ITEM_LASER:   c = COL_LASER;
            default:      c = 12'h000;
        endcase
        return c;
    endfunction

    // Sprite artwork, row-major (bit = row*24 + col), evaluated at elaboration time:
    // addtime = plus, protect = 2-px frame, faster = 4x4 checker, frozen = X, laser = vertical bar.
    function automatic logic [SPRITE_PIX-1:0] sprite_bits(input logic [2:0] sel);
        logic [SPRITE_PIX-1:0] bits;
        logic                  on;
        bits = '0;
        for (int r = 0; r < SPRITE_DEF; r++) begin
            for (int c = 0; c < SPRITE_DEF; c++) begin
                case (sel)
                    SEL_ADDTIME: on = (c >= 10 && c <= 13) || (r >= 10 && r <= 13);
                    SEL_PROTECT: on = (c < 2) || (c > 21) || (r < 2) || (r > 21);
                    SEL_FASTER:  on = (((c >> 2) + (r >> 2)) & 1) == 0;
                    SEL_FROZEN:  on = (c == r) || (c + r == SPRITE_DEF - 1);
                    SEL_LASER:   on = (c >= 9) && (c <= 14);
                    default:     on = 1'b0;
                endcase
                bits[r*SPRITE_DEF + c] = on;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/item_sprite_rom.sv
// Synchronous 1-bit sprite ROM bank: addr = {type_sel, offset}, one cycle read latency.
module item_sprite_rom
    import item_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] addr,
    output logic        dout
);

    localparam logic [SPRITE_PIX-1:0] ROM_ADDTIME = sprite_bits(SEL_ADDTIME);
    localparam logic [SPRITE_PIX-1:0] ROM_PROTECT = sprite_bits(SEL_PROTECT);
    localparam logic [SPRITE_PIX-1:0] ROM_FASTER  = sprite_bits(SEL_FASTER);
    localparam logic [SPRITE_PIX-1:0] ROM_FROZEN  = sprite_bits(SEL_FROZEN);
    localparam logic [SPRITE_PIX-1:0] ROM_LASER   = sprite_bits(SEL_LASER);

    logic [2:0] type_sel;
    logic [9:0] offset;
    logic       in_range;

    assign {type_sel, offset} = addr;
    assign in_range = offset < 10'(SPRITE_PIX);

    // Registered read; offsets past the last pixel read as transparent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= 1'b0;
        end else if (!in_range) begin
            dout <= 1'b0;
        end else begin
            case (type_sel)
                SEL_ADDTIME: dout <= ROM_ADDTIME[offset];
                SEL_PROTECT: dout <= ROM_PROTECT[offset];
                SEL_FASTER:  dout <= ROM_FASTER[offset];
                SEL_FROZEN:  dout <= ROM_FROZEN[offset];
                SEL_LASER:   dout <= ROM_LASER[offset];
                default:     dout <= 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/item_sprite_renderer.sv
// Reward-item layer: slot register file with frame lifetimes, priority hit test,
// and a 2-cycle pixel pipeline (ROM read, colour register) feeding the VGA mux.
module item_sprite_renderer
    import item_pkg::*;
#(
    parameter int N_SLOTS      = 4,
    parameter int GRID_W       = 5,
    parameter int CELL         = CELL_DEF,
    parameter int ORIGIN       = ORIGIN_DEF,
    parameter int SPRITE       = SPRITE_DEF,
    parameter int LIFE_W       = 10,
    parameter int BLINK_FRAMES = 120,
    parameter int BLINK_BIT    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               display_en,
    input  logic               enable_game_classic,
    input  logic               enable_game_infinity,
    input  logic               set_valid,
    input  logic [2:0]         set_slot,
    input  logic [GRID_W-1:0]  set_xgrid,
    input  logic [GRID_W-1:0]  set_ygrid,
    input  logic [2:0]         set_type,
    input  logic [LIFE_W-1:0]  set_life,
    input  logic               clr_valid,
    input  logic [2:0]         clr_slot,
    input  logic [10:0]        VGA_xpos,
    input  logic [10:0]        VGA_ypos,
    output logic [11:0]        VGA_data,
    output logic [N_SLOTS-1:0] item_active,
    output logic [N_SLOTS-1:0] expire_pulse
);

    localparam int HALF   = SPRITE / 2;
    localparam int STAGES = 1;

    logic                      set_ok;
    logic                      life_step;
    logic [N_SLOTS-1:0]        slot_act;
    logic [N_SLOTS-1:0]        slot_exp;
    logic [N_SLOTS-1:0]        slot_hit;
    logic [N_SLOTS-1:0][2:0]   slot_type;
    logic [N_SLOTS-1:0][9:0]   slot_addr;

    // Loads need a real slot, a drawable type and a non-zero lifetime
    assign set_ok = set_valid
                 && ({1'b0, set_slot} < 4'(N_SLOTS))
                 && (set_type >= 3'(ITEM_PROTECT))
                 && (set_type <= 3'(ITEM_LASER))
                 && (set_life != '0);

    // Lifetimes only run while the layer is on screen
    assign life_step = frame_tick && display_en;

    for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
        logic              act_q;
        logic              exp_q;
        logic [GRID_W-1:0] x_q;
        logic [GRID_W-1:0] y_q;
        logic [2:0]        type_q;
        logic [LIFE_W-1:0] life_q;
        logic              set_me;
        logic              clr_me;
        logic              blank;
        logic [10:0]       cx;
        logic [10:0]       cy;
        logic [11:0]       ofs_x;
        logic [11:0]       ofs_y;

        assign set_me = set_ok && (set_slot == 3'(i));
        assign clr_me = clr_valid && (clr_slot == 3'(i));

        // Slot update: set beats pickup, pickup beats countdown; a fresh load skips this tick
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                act_q  <= 1'b0;
                exp_q  <= 1'b0;
                x_q    <= '0;
                y_q    <= '0;
                type_q <= '0;
                life_q <= '0;
            end else begin
                exp_q <= 1'b0;
                if (set_me) begin
                    act_q  <= 1'b1;
                    x_q    <= set_xgrid;
                    y_q    <= set_ygrid;
                    type_q <= set_type;
                    life_q <= set_life;
                end else if (clr_me) begin
                    act_q  <= 1'b0;
                    life_q <= '0;
                end else if (life_step && act_q) begin
                    life_q <= life_q - 1'b1;
                    if (life_q == LIFE_W'(1)) begin
                        act_q <= 1'b0;
                        exp_q <= 1'b1;
                    end
                end
            end
        end

        // Sprite centre in pixels
        assign cx = 11'(int'(x_q) * CELL + ORIGIN);
        assign cy = 11'(int'(y_q) * CELL + ORIGIN);

        // Offset from the sprite's left/top edge; pixels left of it wrap to large values,
        // so a single unsigned compare covers both bounds of the window
        assign ofs_x = {1'b0, VGA_xpos} + 12'(HALF - 1) - {1'b0, cx};
        assign ofs_y = {1'b0, VGA_ypos} + 12'(HALF - 1) - {1'b0, cy};

        // Near end of life the item disappears on alternate 8-frame phases
        assign blank = (life_q <= LIFE_W'(BLINK_FRAMES)) && !life_q[BLINK_BIT];

        assign slot_hit[i]  = act_q && !blank && (ofs_x < 12'(SPRITE)) && (ofs_y < 12'(SPRITE));
        assign slot_addr[i] = 10'(ofs_x) + 10'(int'(ofs_y) * SPRITE);
        assign slot_type[i] = type_q;
        assign slot_act[i]  = act_q;
        assign slot_exp[i]  = exp_q;
    end

    assign item_active  = slot_act;
    assign expire_pulse = slot_exp;

    logic        win_hit;
    logic [9:0]  win_addr;
    logic [2:0]  win_type;
    logic [2:0]  win_sel;

    // Priority encoder: walk downwards so the lowest-index hitting slot is kept
    always_comb begin
        win_hit  = 1'b0;
        win_addr = '0;
        win_type = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                win_hit  = 1'b1;
                win_addr = slot_addr[i];
                win_type = slot_type[i];
            end
        end
        if (!display_en) begin
            win_hit = 1'b0;
        end
    end

    // Type 1 shows the protect shield in classic mode, otherwise the addtime clock
    always_comb begin
        win_sel = win_type;
        if (win_type == 3'(ITEM_PROTECT)) begin
            win_sel = enable_game_classic ? 3'(SEL_PROTECT) : 3'(SEL_ADDTIME);
        end
    end

    logic              rom_bit;
    logic              s1_hit;
    logic [2:0]        s1_type;
    logic [STAGES:0]   vld_pipe;

    item_sprite_rom u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  ({win_sel, win_addr}),
        .dout  (rom_bit)
    );

    assign vld_pipe[0] = display_en;

    // Stage 1: hit and type ride alongside the synchronous ROM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hit      <= 1'b0;
            s1_type     <= '0;
            vld_pipe[1] <= 1'b0;
        end else begin
            s1_hit      <= win_hit;
            s1_type     <= win_type;
            vld_pipe[1] <= vld_pipe[0];
        end
    end

    // Stage 2: colour register; transparent sprite bits and misses are black
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            VGA_data <= 12'h000;
        end else if (vld_pipe[1] && s1_hit && rom_bit) begin
            VGA_data <= type_colour(s1_type);
        end else begin
            VGA_data <= 12'h000;
        end
    end

endmodule
